// File: rtl/imm_encode_loader.sv
// imm_encode_loader
//   Packs RV32I instruction fields and a full 32-bit immediate into a legal
//   instruction word, then streams the words into instruction memory at
//   consecutive word addresses. Each immediate is range-checked when its
//   bundle is accepted. The address of the first committed word that failed
//   the check is kept.
//
// Ports:
//   clock, reset      system clock; asynchronous active-high reset
//   restart           synchronous rewind to BASE_ADDR, drops any pending word
//   in_valid/in_ready field bundle handshake
//   in_fmt            0=R 1=I 2=S 3=B 4=U 5=J (6,7 illegal -> NOP, flagged)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                     instruction fields and signed immediate
//   mem_we/mem_ack    write request, held until acknowledged
//   mem_addr          byte address of the current word
//   mem_wdata         encoded instruction word
//   word_count        committed words since reset/restart (saturating)
//   err, err_addr     sticky error flag and address of first bad word
module imm_encode_loader #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [15:0]       word_count,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [31:0] enc_word;
    logic        enc_bad;
    logic        word_bad;   // range/format flag travelling with mem_wdata
    logic        accept;
    logic        commit;

    assign in_ready = !restart && (!mem_we || mem_ack);
    assign accept   = in_valid && in_ready;
    assign commit   = mem_we && mem_ack;

    // Field packing and range check. Out-of-range values are still packed,
    // truncated to whatever immediate bits the format carries.
    always_comb begin
        enc_word = NOP_WORD;
        enc_bad  = 1'b1;
        case (in_fmt)
            FMT_R: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_bad  = 1'b0;
            end
            FMT_I: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_bad  = ($signed(in_imm) < -2048) || ($signed(in_imm) > 2047);
            end
            FMT_S: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], in_opcode};
                enc_bad  = ($signed(in_imm) < -2048) || ($signed(in_imm) > 2047);
            end
            FMT_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_bad  = ($signed(in_imm) < -4096) || ($signed(in_imm) > 4094)
                           || in_imm[0];
            end
            FMT_U: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                enc_bad  = |in_imm[11:0];
            end
            FMT_J: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
                enc_bad  = ($signed(in_imm) < -1048576)
                           || ($signed(in_imm) > 1048574) || in_imm[0];
            end
            default: begin
                enc_word = NOP_WORD;
                enc_bad  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
            err_addr   <= '0;
            word_bad   <= 1'b0;
        end else if (restart) begin
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
            err_addr   <= '0;
            word_bad   <= 1'b0;
        end else begin
            if (commit) begin
                mem_addr <= mem_addr + ADDR_W'(4);
                if (word_count != 16'hFFFF)
                    word_count <= word_count + 16'd1;
                if (word_bad && !err) begin
                    err      <= 1'b1;
                    err_addr <= mem_addr;
                end
            end
            // A new accept on the commit edge reloads the stage, keeping mem_we
            // high so one word per cycle streams through.
            if (accept) begin
                mem_we    <= 1'b1;
                mem_wdata <= enc_word;
                word_bad  <= enc_bad;
            end else if (commit) begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_encode_loader.sv
module tb_imm_encode_loader;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] word_count;
    logic        err;
    logic [31:0] err_addr;

    imm_encode_loader #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .word_count(word_count),
        .err(err), .err_addr(err_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic        bad;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] word, input logic bad);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.word = word; v.bad = bad;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1;
        in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
    endtask

    task automatic do_restart();
        in_valid = 1'b0;
        restart  = 1'b1;
        #1;
        chk("ready_in_restart", {63'd0, in_ready}, 64'd0);
        tick();
        restart = 1'b0;
    endtask

    // Reference decoder: how the core would read fields back from a word.
    function automatic logic [31:0] dec_imm(input logic [2:0] fmt, input logic [31:0] w);
        case (fmt)
            3'd1: return {{20{w[31]}}, w[31:20]};
            3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4: return {w[31:12], 12'd0};
            3'd5: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    // Register/opcode/funct fields a format carries, unused ones zeroed.
    function automatic logic [31:0] fields_of(input logic [2:0] fmt, input logic [6:0] op,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic has_rd, has_rs1, has_rs2, has_f3, has_f7;
        has_rd  = (fmt == 3'd0) || (fmt == 3'd1) || (fmt == 3'd4) || (fmt == 3'd5);
        has_rs1 = (fmt <= 3'd3);
        has_rs2 = (fmt == 3'd0) || (fmt == 3'd2) || (fmt == 3'd3);
        has_f3  = (fmt <= 3'd3);
        has_f7  = (fmt == 3'd0);
        return {op, has_rd ? rd : 5'd0, has_rs1 ? rs1 : 5'd0, has_rs2 ? rs2 : 5'd0,
                has_f3 ? f3 : 3'd0, has_f7 ? f7 : 7'd0};
    endfunction

    vec_t tbl[$];
    vec_t q[$];
    vec_t v_i, v_b, v_j, v_r, v_s_bad, v_b_bad, v_nop;

    initial begin
        // --- reset state ---
        tick();
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_addr", {32'd0, mem_addr}, {32'd0, BASE});
        chk("rst_count", {48'd0, word_count}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_err_addr", {32'd0, err_addr}, 64'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        //          fmt   op      rd     rs1    rs2    f3    f7     imm              word            bad
        v_i     = mk(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF30293, 1'b0);
        v_b     = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4096,     32'h80208063, 1'b0);
        v_j     = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h001000EF, 1'b0);
        v_r     = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h1234_5678,  32'h002081B3, 1'b0);
        v_s_bad = mk(3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd2, 7'd0, 32'd2048,       32'h80002023, 1'b1);
        v_b_bad = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,          32'h00000163, 1'b1);
        v_nop   = mk(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hDEAD_BEEF, 32'h00000013, 1'b1);
        tbl.push_back(v_i);
        tbl.push_back(v_b);
        tbl.push_back(v_j);
        tbl.push_back(v_r);
        tbl.push_back(v_s_bad);
        tbl.push_back(v_b_bad);
        tbl.push_back(v_nop);
        tbl.push_back(mk(3'd6, 7'h00, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd0, 32'h00000013, 1'b1));
        tbl.push_back(mk(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123453B7, 1'b0));
        tbl.push_back(mk(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h00001037, 1'b1));
        tbl.push_back(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020A423, 1'b0));
        tbl.push_back(mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,     32'h7FF00013, 1'b0));
        tbl.push_back(mk(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2049,   32'h7FF00013, 1'b1));
        tbl.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,     32'h7E000FE3, 1'b0));
        tbl.push_back(mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1048576, 32'h8000006F, 1'b0));
        tbl.push_back(mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576,  32'h8000006F, 1'b1));

        // --- table: one word per restart so each flag is seen in isolation ---
        mem_ack = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            do_restart();
            drive(tbl[i]);
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_we", i), {63'd0, mem_we}, 64'd1);
            chk($sformatf("tbl%0d_wdata", i), {32'd0, mem_wdata}, {32'd0, tbl[i].word});
            chk($sformatf("tbl%0d_addr", i), {32'd0, mem_addr}, {32'd0, BASE});
            tick();
            chk($sformatf("tbl%0d_err", i), {63'd0, err}, {63'd0, tbl[i].bad});
            chk($sformatf("tbl%0d_err_addr", i), {32'd0, err_addr},
                {32'd0, tbl[i].bad ? BASE : 32'd0});
            chk($sformatf("tbl%0d_count", i), {48'd0, word_count}, 64'd1);
            chk($sformatf("tbl%0d_we_off", i), {63'd0, mem_we}, 64'd0);
        end

        // --- back-to-back B then J, no bubble ---
        do_restart();
        drive(v_b);
        tick();
        drive(v_j);
        chk("b2b_w0", {32'd0, mem_wdata}, 64'h80208063);
        chk("b2b_a0", {32'd0, mem_addr}, {32'd0, BASE});
        chk("b2b_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_we1", {63'd0, mem_we}, 64'd1);
        chk("b2b_w1", {32'd0, mem_wdata}, 64'h001000EF);
        chk("b2b_a1", {32'd0, mem_addr}, {32'd0, BASE + 32'd4});
        tick();
        chk("b2b_count", {48'd0, word_count}, 64'd2);
        chk("b2b_err", {63'd0, err}, 64'd0);

        // --- two flagged words: only the first sets err_addr ---
        do_restart();
        drive(v_s_bad);
        tick();
        drive(v_b_bad);
        tick();
        in_valid = 1'b0;
        tick();
        chk("err2_err", {63'd0, err}, 64'd1);
        chk("err2_addr", {32'd0, err_addr}, {32'd0, BASE});
        chk("err2_count", {48'd0, word_count}, 64'd2);

        // clean word first, then two bad ones
        do_restart();
        drive(v_i);
        tick();
        drive(v_s_bad);
        tick();
        drive(v_b_bad);
        tick();
        in_valid = 1'b0;
        tick();
        chk("err3_addr", {32'd0, err_addr}, {32'd0, BASE + 32'd4});
        chk("err3_count", {48'd0, word_count}, 64'd3);

        // --- stall with mem_ack low ---
        do_restart();
        mem_ack = 1'b0;
        drive(v_i);
        tick();
        drive(v_r);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_ready", c), {63'd0, in_ready}, 64'd0);
            chk($sformatf("stall%0d_wdata", c), {32'd0, mem_wdata}, 64'hFFF30293);
            chk($sformatf("stall%0d_addr", c), {32'd0, mem_addr}, {32'd0, BASE});
            chk($sformatf("stall%0d_we", c), {63'd0, mem_we}, 64'd1);
            tick();
        end
        chk("stall_count", {48'd0, word_count}, 64'd0);
        mem_ack = 1'b1;
        #1;
        chk("stall_ready_ack", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("stall_next_w", {32'd0, mem_wdata}, 64'h002081B3);
        chk("stall_next_a", {32'd0, mem_addr}, {32'd0, BASE + 32'd4});
        chk("stall_next_c", {48'd0, word_count}, 64'd1);
        tick();
        chk("stall_end_c", {48'd0, word_count}, 64'd2);

        // --- restart while a flagged word is pending ---
        do_restart();
        mem_ack = 1'b0;
        drive(v_nop);
        tick();
        in_valid = 1'b0;
        tick();
        chk("rs_pending_we", {63'd0, mem_we}, 64'd1);
        restart = 1'b1;
        #1;
        chk("rs_ready", {63'd0, in_ready}, 64'd0);
        tick();
        restart = 1'b0;
        chk("rs_we", {63'd0, mem_we}, 64'd0);
        chk("rs_addr", {32'd0, mem_addr}, {32'd0, BASE});
        chk("rs_count", {48'd0, word_count}, 64'd0);
        chk("rs_err", {63'd0, err}, 64'd0);
        mem_ack = 1'b1;
        tick();
        tick();
        chk("rs_no_commit", {48'd0, word_count}, 64'd0);
        chk("rs_no_err", {63'd0, err}, 64'd0);

        // --- randomized in-range bundles, round-trip decoded ---
        do_restart();
        begin
            int accepted = 0;
            int committed = 0;
            int cycles = 0;
            logic [31:0] model_addr = BASE;
            vec_t v, r;
            logic exp_ready;
            while ((accepted < 1000 || q.size() != 0) && cycles < 20000) begin
                v.fmt = 3'($urandom_range(0, 5));
                v.op  = 7'($urandom);
                v.rd  = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
                v.f3  = 3'($urandom); v.f7 = 7'($urandom);
                case (v.fmt)
                    3'd1, 3'd2: v.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                    3'd3: v.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                    3'd5: v.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
                    3'd4: v.imm = $urandom & 32'hFFFF_F000;
                    default: v.imm = $urandom;
                endcase
                v.word = '0; v.bad = 1'b0;
                in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1;
                in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
                in_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
                mem_ack  = ($urandom_range(0, 3) != 0);
                #1;
                exp_ready = (q.size() == 0) || mem_ack;
                chk("rnd_ready", {63'd0, in_ready}, {63'd0, exp_ready});
                chk("rnd_we", {63'd0, mem_we}, {63'd0, q.size() != 0});
                if (q.size() != 0 && mem_ack) begin
                    r = q.pop_front();
                    chk("rnd_addr", {32'd0, mem_addr}, {32'd0, model_addr});
                    chk("rnd_fields",
                        {32'd0, fields_of(r.fmt, mem_wdata[6:0], mem_wdata[11:7],
                                          mem_wdata[19:15], mem_wdata[24:20],
                                          mem_wdata[14:12], mem_wdata[31:25])},
                        {32'd0, fields_of(r.fmt, r.op, r.rd, r.rs1, r.rs2, r.f3, r.f7)});
                    if (r.fmt != 3'd0)
                        chk("rnd_imm", {32'd0, dec_imm(r.fmt, mem_wdata)}, {32'd0, r.imm});
                    model_addr = model_addr + 32'd4;
                    committed++;
                end
                if (in_valid && exp_ready) begin
                    q.push_back(v);
                    accepted++;
                end
                @(posedge clock);
                #1;
                cycles++;
            end
            if (cycles >= 20000)
                chk("rnd_timeout", 64'd1, 64'd0);
            in_valid = 1'b0;
            chk("rnd_count", {48'd0, word_count}, {48'd0, 16'(committed)});
            chk("rnd_final_addr", {32'd0, mem_addr}, {32'd0, model_addr});
            chk("rnd_err", {63'd0, err}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_encode_loader.md
Name: imm_encode_loader

Overview:
- Inverse of the core's immediate decode path: packs instruction fields plus a full 32-bit immediate into a legal RV32I instruction word.
- Streams the packed words into instruction memory at consecutive word addresses.
- Used by the test/boot loader to build programs in I-mem without an external assembler.
- Range-checks every immediate and flags the first offending word.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- BASE_ADDR, 0, byte address of the first word written after reset or restart; must be 4-aligned.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- restart  in  1  synchronous pulse: drop any pending word, rewind to BASE_ADDR, clear count/err
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted on a clock edge where in_valid && in_ready
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode field, placed verbatim in bits 6:0
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  bits 14:12
- in_funct7  in  7  bits 31:25, R format only
- in_imm  in  32  signed immediate value (U: full value, low 12 bits expected 0)
- mem_we  out  1  write request; held until acked
- mem_addr  out  ADDR_W  byte address of the current word
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepts the word on an edge where mem_we && mem_ack
- word_count  out  16  words committed since reset/restart, saturating
- err  out  1  sticky: some committed word had a range/format error
- err_addr  out  ADDR_W  mem_addr of the first erroneous committed word

Behaviour:
- Reset (async): mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR, word_count=0, err=0, err_addr=0, internal err bit=0. in_ready=1 once reset deasserts.
- in_ready = !restart && (!mem_we || mem_ack). Output is a single register stage with full throughput: one word per cycle when mem_ack is tied high.
- Latency: bundle accepted at edge N -> mem_we=1 with the encoded word from edge N onward, i.e. visible in cycle N+1.
- Encoding (msb..lsb, each followed by opcode):
  - R: funct7|rs2|rs1|f3|rd.
  - I: imm[11:0]|rs1|f3|rd.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0].
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11].
  - U: imm[31:12]|rd.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
  - Unused fields for a format are ignored.
- Range check, computed at accept and stored with the word:
  - I/S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: never errors.
- Out-of-range immediates are still encoded, truncated to the field bits.
- fmt 6/7: word replaced by 32'h00000013 (NOP) and flagged.
- Commit on (mem_we && mem_ack):
  - mem_addr += 4, wrapping mod 2^ADDR_W.
  - word_count += 1, saturating at 16'hFFFF.
  - If the word is flagged and err==0: err<=1 and err_addr<=mem_addr. Later errors do not update err_addr.
- Commit and new accept on the same edge: the new word loads, mem_we stays 1, and mem_addr advances.
- restart (highest priority, synchronous):
  - mem_we<=0, pending word discarded and not counted.
  - mem_addr<=BASE_ADDR, word_count<=0, err<=0, err_addr<=0.
  - in_ready=0 during the restart cycle.
- mem_wdata and mem_addr are stable while mem_we=1 and !mem_ack.
- Round-trip invariant: for any in-range bundle, the core's immediate decode of mem_wdata equals in_imm.

Test Plan:
- Reset then I-type addi x5,x6,-1 (opcode 13, f3 0, imm -1), mem_ack=1 -> cycle after accept: mem_we=1, addr 0, wdata 32'hFFF30293; next edge word_count=1.
- B-type beq x1,x2,-4096 then J-type jal x1,+2048 back-to-back, ack=1 -> wdata 32'h80208063 at addr 0, 32'h001000EF at addr 4, err=0, no bubble.
- S-type imm=2048 then B-type imm=3 (odd) -> both written; err=1, err_addr=0 (first only), word_count=2.
- Hold mem_ack=0 for 5 cycles with in_valid=1 -> in_ready=0, wdata/addr stable; ack=1 -> commit, next word loads same edge, addr 4.
- restart asserted while a word is pending unacked -> next cycle mem_we=0, addr=BASE_ADDR, word_count=0, err=0; the discarded word is never committed.
- fmt=7 with any fields -> wdata 32'h00000013 written, err=1; then 1000 randomized in-range bundles, each checked through the decoder round-trip -> all match.
